// File: rtl/sdes_pkg.sv
// Shared types and widths for the S-DES CBC sequencer.
package sdes_pkg;

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        READY = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam int BLK_W  = 8;
    localparam int KEY_W  = 10;
    localparam int SBOX_W = 32;
    localparam int CNT_W  = 4;

endpackage

// File: rtl/sdes_cbc_ctrl.sv
// CBC-mode byte-stream sequencer driving an external S-DES core.
// Holds core inputs stable for CORE_LAT edges, then captures and emits.
module sdes_cbc_ctrl
    import sdes_pkg::*;
#(
    parameter int CORE_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_load,
    input  logic [KEY_W-1:0]  cfg_key,
    input  logic [SBOX_W-1:0] cfg_s0,
    input  logic [SBOX_W-1:0] cfg_s1,
    input  logic [BLK_W-1:0]  cfg_iv,
    input  logic [BLK_W-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [BLK_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BLK_W-1:0]  core_plaintext,
    output logic [KEY_W-1:0]  core_key,
    output logic [SBOX_W-1:0] core_s0,
    output logic [SBOX_W-1:0] core_s1,
    input  logic [BLK_W-1:0]  core_ciphertext,
    output logic              busy,
    output logic [15:0]       blk_count
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CORE_LAT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BLK_W-1:0]   r_chain;
    logic [CNT_W-1:0]   r_cnt;
    logic [BLK_W-1:0]   r_out_data;
    logic               r_out_valid;
    logic [BLK_W-1:0]   r_pt;
    logic [KEY_W-1:0]   r_key;
    logic [SBOX_W-1:0]  r_s0;
    logic [SBOX_W-1:0]  r_s1;
    logic [15:0]        r_blk;

    logic               w_cfg_en;
    logic               w_accept;
    logic               w_capture;
    logic               w_handshake;
    logic [BLK_W-1:0]   w_chain_src;

    assign w_cfg_en    = cfg_load && (r_state == UNCFG || r_state == READY);
    assign w_accept    = in_valid && (r_state == READY);
    assign w_capture   = (r_state == WAIT) && (r_cnt == LAST);
    assign w_handshake = r_out_valid && out_ready;
    // A same-cycle reload must chain from the new IV, not the stale one.
    assign w_chain_src = w_cfg_en ? cfg_iv : r_chain;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            UNCFG:   if (cfg_load)    w_state_nxt = READY;
            READY:   if (in_valid)    w_state_nxt = WAIT;
            WAIT:    if (w_capture)   w_state_nxt = OUT;
            OUT:     if (w_handshake) w_state_nxt = READY;
            default:                  w_state_nxt = UNCFG;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= UNCFG;
            r_chain     <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_pt        <= '0;
            r_key       <= '0;
            r_s0        <= '0;
            r_s1        <= '0;
            r_blk       <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cfg_en) begin
                r_key   <= cfg_key;
                r_s0    <= cfg_s0;
                r_s1    <= cfg_s1;
                r_chain <= cfg_iv;
                r_blk   <= '0;
            end
            if (w_accept) begin
                r_pt  <= in_data ^ w_chain_src;
                r_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_capture) begin
                r_out_data  <= core_ciphertext;
                r_chain     <= core_ciphertext;
                r_out_valid <= 1'b1;
            end else if (w_handshake) begin
                r_out_valid <= 1'b0;
                r_blk       <= r_blk + 16'd1;
            end
        end
    end

    assign in_ready       = (r_state == READY);
    assign busy           = (r_state == WAIT) || (r_state == OUT);
    assign out_data       = r_out_data;
    assign out_valid      = r_out_valid;
    assign core_plaintext = r_pt;
    assign core_key       = r_key;
    assign core_s0        = r_s0;
    assign core_s1        = r_s1;
    assign blk_count      = r_blk;

endmodule

// File: tb/tb_sdes_cbc_ctrl.sv
// Directed bench for sdes_cbc_ctrl with a behavioural S-DES core
// model (packed S-box tables, CORE_LAT-edge pipeline) beside it.
module tb_sdes_cbc_ctrl;

    localparam int LAT = 4;
    localparam logic [9:0]  KEY = 10'b1010000010;
    localparam logic [31:0] S0T = 32'hB7D81BB1;
    localparam logic [31:0] S1T = 32'hC613D2E4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_load = 1'b0;
    logic [9:0]  cfg_key = '0;
    logic [31:0] cfg_s0 = '0;
    logic [31:0] cfg_s1 = '0;
    logic [7:0]  cfg_iv = '0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  core_plaintext;
    logic [9:0]  core_key;
    logic [31:0] core_s0;
    logic [31:0] core_s1;
    logic [7:0]  core_ciphertext;
    logic        busy;
    logic [15:0] blk_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    logic [7:0] mon_q[$];
    logic [7:0] pipe [0:LAT-2];

    sdes_cbc_ctrl #(.CORE_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .cfg_load(cfg_load),
        .cfg_key(cfg_key), .cfg_s0(cfg_s0), .cfg_s1(cfg_s1),
        .cfg_iv(cfg_iv), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .core_plaintext(core_plaintext), .core_key(core_key),
        .core_s0(core_s0), .core_s1(core_s1),
        .core_ciphertext(core_ciphertext), .busy(busy),
        .blk_count(blk_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // S-box lookup: entry row*4+col, 2 bits each, LSB-first packing.
    function automatic logic [1:0] sb(input logic [31:0] t,
                                      input logic [3:0] x);
        int idx;
        idx = int'({x[3], x[0]}) * 4 + int'({x[2], x[1]});
        return t[2*idx +: 2];
    endfunction

    function automatic logic [7:0] p8(input logic [9:0] q);
        return {q[4], q[7], q[3], q[6], q[2], q[5], q[0], q[1]};
    endfunction

    function automatic logic [7:0] fk(input logic [7:0] x,
                                      input logic [7:0] k,
                                      input logic [31:0] t0,
                                      input logic [31:0] t1);
        logic [3:0] r;
        logic [7:0] e;
        logic [3:0] s;
        r = x[3:0];
        e = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]} ^ k;
        s = {sb(t0, e[7:4]), sb(t1, e[3:0])};
        return {x[7:4] ^ {s[2], s[0], s[1], s[3]}, r};
    endfunction

    function automatic logic [7:0] sdes(input logic [7:0] p,
                                        input logic [9:0] k,
                                        input logic [31:0] t0,
                                        input logic [31:0] t1);
        logic [9:0] q;
        logic [4:0] l, r;
        logic [7:0] k1, k2, y;
        q = {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
        l = {q[8:5], q[9]};
        r = {q[3:0], q[4]};
        k1 = p8({l, r});
        l = {l[2:0], l[4:3]};
        r = {r[2:0], r[4:3]};
        k2 = p8({l, r});
        y = {p[6], p[2], p[5], p[7], p[4], p[0], p[3], p[1]};
        y = fk(y, k1, t0, t1);
        y = {y[3:0], y[7:4]};
        y = fk(y, k2, t0, t1);
        return {y[4], y[7], y[5], y[3], y[1], y[6], y[0], y[2]};
    endfunction

    always @(posedge clk) begin
        pipe[0] <= sdes(core_plaintext, core_key, core_s0, core_s1);
        for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign core_ciphertext = pipe[LAT-2];

    always @(negedge clk)
        if (mon_en && out_valid && out_ready) mon_q.push_back(out_data);

    task automatic do_cfg(input logic [9:0] k, input logic [7:0] iv);
        @(negedge clk);
        cfg_key = k; cfg_s0 = S0T; cfg_s1 = S1T; cfg_iv = iv;
        cfg_load = 1'b1;
        @(posedge clk); #1;
        cfg_load = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input bit with_cfg,
                        output int lat, output logic [7:0] pt,
                        output logic [7:0] ct);
        @(negedge clk);
        in_data = d; in_valid = 1'b1; cfg_load = with_cfg;
        @(posedge clk); #1;
        in_valid = 1'b0; cfg_load = 1'b0;
        pt = core_plaintext;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); lat++; #1;
        end
        ct = out_data;
    endtask

    task automatic pop;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=000",
                     {in_ready, out_valid, busy});
        end
        checks++;
        if ({out_data, core_plaintext, core_key, blk_count} !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h/%h/%h want=0",
                     out_data, core_plaintext, core_key, blk_count);
        end
        checks++;
        if ({core_s0, core_s1} !== '0) begin
            failures++;
            $display("FAIL reset_sbox got=%h/%h want=0", core_s0, core_s1);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int lat;
        logic [7:0] pt, ct;
        do_cfg(KEY, 8'h00);
        checks++;
        if (core_key !== KEY || core_s0 !== S0T || core_s1 !== S1T) begin
            failures++;
            $display("FAIL basic_cfg key got=%b want=%b", core_key, KEY);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_ready got=%b want=1", in_ready);
        end
        push(8'h72, 1'b0, lat, pt, ct);
        checks++;
        if (pt !== 8'h72) begin
            failures++;
            $display("FAIL basic_pt got=%h want=72", pt);
        end
        checks++;
        if (lat !== LAT) begin
            failures++;
            $display("FAIL basic_latency got=%0d want=%0d", lat, LAT);
        end
        checks++;
        if (ct !== 8'h77) begin
            failures++;
            $display("FAIL basic_ct got=%h want=77", ct);
        end
        pop();
        checks++;
        if (blk_count !== 16'd1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done blk=%0d ov=%b busy=%b want 1/0/0",
                     blk_count, out_valid, busy);
        end
    endtask

    task automatic test_chaining;
        int lat;
        logic [7:0] pt, ct;
        push(8'h72, 1'b0, lat, pt, ct);
        checks++;
        if (pt !== 8'h05) begin
            failures++;
            $display("FAIL chain_pt got=%h want=05", pt);
        end
        checks++;
        if (ct !== sdes(8'h05, KEY, S0T, S1T)) begin
            failures++;
            $display("FAIL chain_ct got=%h want=%h", ct,
                     sdes(8'h05, KEY, S0T, S1T));
        end
        pop();
        checks++;
        if (blk_count !== 16'd2) begin
            failures++;
            $display("FAIL chain_blk got=%0d want=2", blk_count);
        end
        do_cfg(KEY, 8'h00);
        checks++;
        if (blk_count !== 16'd0) begin
            failures++;
            $display("FAIL chain_blk_clr got=%0d want=0", blk_count);
        end
        push(8'h72, 1'b0, lat, pt, ct);
        checks++;
        if (ct !== 8'h77) begin
            failures++;
            $display("FAIL chain_restart got=%h want=77", ct);
        end
        pop();
    endtask

    task automatic test_backpressure;
        int lat;
        logic [7:0] pt, ct, ct0, want;
        push(8'hA5, 1'b0, lat, pt, ct0);
        want = sdes(8'hD2, KEY, S0T, S1T);
        checks++;
        if (pt !== 8'hD2 || ct0 !== want) begin
            failures++;
            $display("FAIL bp_block pt=%h ct=%h want D2/%h", pt, ct0, want);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) begin
                cfg_key = 10'h155; cfg_iv = 8'hFF; cfg_load = 1'b1;
            end else begin
                cfg_load = 1'b0;
            end
            checks++;
            if (out_valid !== 1'b1 || out_data !== ct0 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d ov=%b od=%h ir=%b want 1/%h/0",
                         i, out_valid, out_data, in_ready, ct0);
            end
        end
        cfg_load = 1'b0;
        checks++;
        if (core_key !== KEY) begin
            failures++;
            $display("FAIL bp_cfg_ignored got=%b want=%b", core_key, KEY);
        end
        pop();
        checks++;
        if (blk_count !== 16'd2 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release blk=%0d ov=%b want 2/0",
                     blk_count, out_valid);
        end
        cfg_key = KEY; cfg_iv = 8'h00;
        push(8'h11, 1'b0, lat, pt, ct);
        checks++;
        if (pt !== (8'h11 ^ ct0)) begin
            failures++;
            $display("FAIL bp_chain_kept got=%h want=%h", pt, 8'h11 ^ ct0);
        end
        pop();
    endtask

    task automatic test_cfg_same_cycle;
        int lat;
        logic [7:0] pt, ct;
        cfg_key = KEY; cfg_iv = 8'h05;
        push(8'h77, 1'b1, lat, pt, ct);
        checks++;
        if (pt !== 8'h72) begin
            failures++;
            $display("FAIL same_cycle_pt got=%h want=72", pt);
        end
        checks++;
        if (ct !== 8'h77) begin
            failures++;
            $display("FAIL same_cycle_ct got=%h want=77", ct);
        end
        pop();
        checks++;
        if (blk_count !== 16'd1) begin
            failures++;
            $display("FAIL same_cycle_blk got=%0d want=1", blk_count);
        end
    endtask

    task automatic test_unconfigured;
        @(negedge clk);
        reset = 1'b1;
        #2 reset = 1'b0;
        in_data = 8'h5A; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || core_plaintext !== 8'h00 || busy !== 1'b0) begin
                failures++;
                $display("FAIL uncfg cyc=%0d ir=%b pt=%h busy=%b want 0/00/0",
                         i, in_ready, core_plaintext, busy);
            end
        end
        in_valid = 1'b0;
        do_cfg(KEY, 8'h00);
        checks++;
        if (in_ready !== 1'b1 || core_plaintext !== 8'h00) begin
            failures++;
            $display("FAIL uncfg_cfg ir=%b pt=%h want 1/00",
                     in_ready, core_plaintext);
        end
    endtask

    task automatic test_reset_wait;
        @(negedge clk);
        in_data = 8'h72; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_wait_pre busy=%b ov=%b want 1/0", busy, out_valid);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, out_valid, in_ready} !== 3'b000 ||
            {core_plaintext, core_key, out_data, blk_count} !== '0) begin
            failures++;
            $display("FAIL rst_wait_async busy=%b ov=%b pt=%h key=%h",
                     busy, out_valid, core_plaintext, core_key);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL rst_wait_uncfg cyc=%0d ov=%b ir=%b want 0/0",
                         i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_streaming;
        logic [7:0] b [8];
        int acc [8];
        int guard;
        logic [7:0] chain, want;
        b = '{8'h00, 8'hFF, 8'h72, 8'h72, 8'h3C, 8'hA5, 8'h01, 8'h80};
        do_cfg(KEY, 8'h3C);
        mon_q.delete();
        out_ready = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_data = b[i]; in_valid = 1'b1;
            guard = 0;
            while (!in_ready && guard < 20) begin
                @(negedge clk); guard++;
            end
            acc[i] = cyc;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        guard = 0;
        while (mon_q.size() < 8 && guard < 50) begin
            @(negedge clk); guard++;
        end
        mon_en = 1'b0;
        out_ready = 1'b0;
        for (int i = 1; i < 8; i++) begin
            checks++;
            if (acc[i] - acc[i-1] != LAT + 2) begin
                failures++;
                $display("FAIL stream_rate idx=%0d got=%0d want=%0d",
                         i, acc[i] - acc[i-1], LAT + 2);
            end
        end
        checks++;
        if (mon_q.size() != 8) begin
            failures++;
            $display("FAIL stream_count got=%0d want=8", mon_q.size());
        end else begin
            chain = 8'h3C;
            for (int i = 0; i < 8; i++) begin
                want = sdes(b[i] ^ chain, KEY, S0T, S1T);
                chain = want;
                checks++;
                if (mon_q[i] !== want) begin
                    failures++;
                    $display("FAIL stream_ct idx=%0d got=%h want=%h",
                             i, mon_q[i], want);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (blk_count !== 16'd8) begin
            failures++;
            $display("FAIL stream_blk got=%0d want=8", blk_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_chaining();
        test_backpressure();
        test_cfg_same_cycle();
        test_unconfigured();
        test_reset_wait();
        do_cfg(KEY, 8'h00);
        test_streaming();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdes_cbc_ctrl.md
# sdes_cbc_ctrl

- Upstream sequencer for the S_DES core; turns it into a CBC-mode byte-stream encryptor.
- Accepts plaintext bytes on a valid/ready stream and XORs each byte with the chaining value (IV, then the previous ciphertext).
- Presents the result to the core and holds it stable for a fixed core latency.
- Captures the core ciphertext and emits it on an output valid/ready stream.
- Holds the key, S-box tables and IV, and drives them to the core.

## Interface
Parameters:
- CORE_LAT, 4, rising edges from a `core_plaintext` update to a valid `core_ciphertext`; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  reset is asynchronous and active-high.
- cfg_load  in  1  single-cycle pulse; latches `cfg_*` and restarts the chain.
- cfg_key  in  10  S-DES key.
- cfg_s0  in  32  S0 table, packed as the core expects.
- cfg_s1  in  32  S1 table, packed as the core expects.
- cfg_iv  in  8  CBC initialisation vector.
- in_data  in  8  plaintext byte.
- in_valid  in  1  `in_data` is valid.
- in_ready  out  1  block accepts `in_data` this cycle.
- out_data  out  8  ciphertext byte.
- out_valid  out  1  `out_data` is valid.
- out_ready  in  1  sink accepts `out_data`.
- core_plaintext  out  8  registered plaintext to the core.
- core_key  out  10  registered key to the core.
- core_s0  out  32  registered S0 table to the core.
- core_s1  out  32  registered S1 table to the core.
- core_ciphertext  in  8  ciphertext from the core.
- busy  out  1  high in WAIT or OUT.
- blk_count  out  16  blocks emitted since the last `cfg_load`; wraps at 0xFFFF→0.

## Operation
- **FSM states:** UNCFG, READY, WAIT, OUT.
- **UNCFG:** `in_ready`=0. `cfg_load` → READY.
- **READY:** `in_ready`=1.
  - `cfg_load` reloads the config and stays in READY; `in_ready` stays 1 during that cycle.
  - `in_valid`&`in_ready` in the same cycle as `cfg_load`: the byte is accepted, and the XOR uses the NEW `cfg_iv`.
  - Otherwise, on `in_valid`&`in_ready`: `core_plaintext` <= `in_data` ^ chain, `cnt` <= 0, go to WAIT.
- **WAIT:** `cnt` increments each edge. On the edge where `cnt`==CORE_LAT-1:
  - `out_data` <= `core_ciphertext`;
  - chain <= `core_ciphertext`;
  - `out_valid` <= 1;
  - go to OUT.
- **OUT:** `out_valid`=1 and `out_data` is held stable until `out_valid`&`out_ready`. Then `out_valid` <= 0, `blk_count` += 1, go to READY.
- **cfg_load:** latches `cfg_key`/`cfg_s0`/`cfg_s1` into `core_key`/`core_s0`/`core_s1`, latches `cfg_iv` into chain, and clears `blk_count`.
  - Honoured only in UNCFG or READY.
  - Ignored in WAIT and OUT, so the core inputs never change mid-block.
- **Chaining:** chain holds the last emitted ciphertext. It updates at capture, not at the output handshake.
- **Widths:** all datapath XORs are 8-bit. `cnt` is 4-bit.

## Timing
- **Reset values** (asynchronous, while `reset`=1):
  - state=UNCFG;
  - `in_ready`=0, `out_valid`=0, `busy`=0;
  - `out_data`, `core_plaintext`, `core_key`, `core_s0`, `core_s1`, chain, `cnt`, `blk_count` all 0.
- **Latency:** input accepted at edge N → `core_plaintext` valid after N → capture at edge N+CORE_LAT → `out_valid` high from N+CORE_LAT.
- **Throughput:** with `out_ready` tied high, the output handshake happens at N+CORE_LAT+1 and the next input is accepted at N+CORE_LAT+2. Peak rate is one byte per CORE_LAT+2 cycles.
- **Ready/valid:** `in_ready` is a function of state only. `out_valid`, once raised, never drops without a handshake.
- **Reset mid-block** (WAIT or OUT):
  - the in-flight byte is discarded;
  - config is lost;
  - the block returns to UNCFG and must be reconfigured.
- **`blk_count` wrap:** the 65536th emitted block leaves `blk_count`=0.

## Structure
- **Shared package `sdes_pkg`:**
  - state enum (UNCFG, READY, WAIT, OUT);
  - constants BLK_W=8, KEY_W=10, SBOX_W=32, CNT_W=4.
- **Sub-modules:** none. The S_DES core is instantiated beside this block at the next level up: `core_*` outputs connect to its inputs, and its `ciphertext` output connects to `core_ciphertext`.

## Test plan
All scenarios use the real S_DES core.
1. **Basic block:** reset, then `cfg_load` with key=1010000010, S0=0xB7D81BB1, S1=0xC613D2E4, IV=0x00; send `in_data`=0x72 → `core_plaintext`=0x72, `out_data`=0x77 with `out_valid` rising exactly CORE_LAT edges after acceptance, `blk_count`=1.
2. **Chaining:** after scenario 1, send 0x72 again → `core_plaintext`=0x05 (0x72^0x77); `out_data` equals the core's E(0x05); a fresh `cfg_load` with IV=0x00 followed by 0x72 → `out_data`=0x77 again.
3. **Backpressure:** hold `out_ready`=0 for 10 cycles in OUT → `out_data` stable, `in_ready`=0, `cfg_load` ignored (`core_key` unchanged); release → one handshake, `blk_count`+1.
4. **Unconfigured:** assert `in_valid` in UNCFG → `in_ready`=0 and no `core_plaintext` change until `cfg_load`.
5. **Async reset in WAIT:** assert `reset` mid-WAIT → all outputs 0 immediately, no `out_valid`, state UNCFG.
6. **Streaming:** 8 bytes, `out_ready`=1 → inputs accepted every CORE_LAT+2 cycles; outputs match a CBC reference model.
